// File: rtl/phase_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// phase_sequencer_pkg : shared sequencer state encodings and helpers
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package phase_sequencer_pkg;

    // 3-bit encodings are stable so debug/LED display logic can decode them.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } seq_state_e;

    function automatic logic is_active(input seq_state_e s);
        return (s == S_RUN) || (s == S_STEP) || (s == S_DRAIN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_sequencer_edge_rise.sv
// ----------------------------------------------------------------------------
// edge_rise : rising-edge detector for a level button/request input
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module edge_rise (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // History tracks the input on every clock, reset included, so a request
    // held high across reset release is not seen as a fresh edge.
    always_ff @(posedge clock) begin
        d_q <= d;
    end

    assign rise = ~reset & d & ~d_q;

endmodule

`default_nettype wire

// File: rtl/phase_sequencer.sv
// ----------------------------------------------------------------------------
// phase_sequencer : parametrised instruction-phase sequencer with run/step/halt
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int N_PHASES = 5,
    parameter int CNT_W    = 16,
    parameter int PHASE_W  = $clog2(N_PHASES)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                exec,
    input  logic                step,
    input  logic                halt,
    input  logic                stall,
    output logic [N_PHASES-1:0] phase_en,
    output logic [PHASE_W-1:0]  phase,
    output logic                running,
    output logic                halted,
    output logic                cycle_done,
    output logic [CNT_W-1:0]    cycle_count
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(N_PHASES - 1);

    logic exec_rise;
    logic step_rise;

    edge_rise u_exec_edge (
        .clock (clock),
        .reset (reset),
        .d     (exec),
        .rise  (exec_rise)
    );

    edge_rise u_step_edge (
        .clock (clock),
        .reset (reset),
        .d     (step),
        .rise  (step_rise)
    );

    seq_state_e         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               done_q;
    logic [CNT_W-1:0]   count_q;
    logic               active;
    logic               retire;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        active  = is_active(state_q);
        retire  = active & ~stall & (phase_q == LAST_PHASE);

        unique case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (exec_rise) begin
                    state_d = S_RUN;
                end else if (step_rise) begin
                    state_d = S_STEP;
                end
            end
            S_RUN, S_STEP, S_DRAIN: begin
                if (!stall) begin
                    phase_d = retire ? '0 : phase_q + PHASE_W'(1);
                    // A stop edge landing on the last phase simply ends the cycle.
                    if (retire) begin
                        if (halt) begin
                            state_d = S_HALTED;
                        end else if (state_q == S_RUN && !exec_rise) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (state_q == S_RUN && exec_rise) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_HALTED: begin
                phase_d = '0;
                if (exec_rise) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            done_q  <= retire;
            count_q <= count_q + CNT_W'(retire);
        end
    end

    assign phase_en    = is_active(state_q) ? (N_PHASES'(1) << phase_q) : '0;
    assign phase       = phase_q;
    assign running     = is_active(state_q);
    assign halted      = (state_q == S_HALTED);
    assign cycle_done  = done_q;
    assign cycle_count = count_q;

endmodule

`default_nettype wire
